// File: rtl/spi_dac_pkg.sv
// Shared types and defaults for the streaming SPI DAC master.
// Holds the FSM state enum, default parameters and frame-size helper.
package spi_dac_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CFG,
        ST_ADDR,
        ST_DATA,
        ST_GAP
    } state_t;

    localparam int DEF_CLK_DIV = 6;
    localparam int DEF_NUM_CH  = 8;
    localparam int DEF_DATA_W  = 16;
    localparam int DEF_ADDR_W  = 8;
    localparam int DEF_CFG_W   = 24;
    localparam int DEF_CS_GAP  = 2;

    // Bits in one burst frame: address phase plus all samples.
    function automatic int bits_per_frame(
        input int addr_w,
        input int num_ch,
        input int data_w
    );
        return addr_w + num_ch * data_w;
    endfunction

endpackage

// File: rtl/spi_dac_bit_timer.sv
// SCLK divider and bit counter for the SPI DAC master.
// Ports: clk, rst, en, nbits (bits in current phase) -> bit_start,
// bit_end, bit_last (end of phase), sclk_rise, sclk (raw level).
module spi_dac_bit_timer
    import spi_dac_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV,
    parameter int BW      = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [BW-1:0] nbits,
    output logic          bit_start,
    output logic          bit_end,
    output logic          bit_last,
    output logic          sclk_rise,
    output logic          sclk
);

    localparam int DW = $clog2(CLK_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);

    logic [DW-1:0] div_cnt;
    logic [BW-1:0] bit_cnt;

    assign bit_start = en && (div_cnt == '0);
    assign bit_end   = en && (div_cnt == DIV_LAST);
    assign bit_last  = bit_end && (bit_cnt == nbits - BW'(1));
    // sclk goes high on the edge that ends this cycle
    assign sclk_rise = en && (div_cnt == DIV_HALF - DW'(1));
    assign sclk      = en && (div_cnt >= DIV_HALF);

    // Counters restart at every phase boundary so each phase
    // begins on a fresh bit with sclk low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
            bit_cnt <= '0;
        end else if (!en || bit_last) begin
            div_cnt <= '0;
            bit_cnt <= '0;
        end else if (bit_end) begin
            div_cnt <= '0;
            bit_cnt <= bit_cnt + BW'(1);
        end else begin
            div_cnt <= div_cnt + DW'(1);
        end
    end

endmodule

// File: rtl/spi_dac_stream.sv
// SPI master for a multi-channel DAC: config frame, then address+sample bursts.
// Ports: sample bus (s_valid/s_ready/s_data/start_addr), cfg_word/cfg_req,
// status pulses, SPI pins; readback of sdo during CFG under SPI_DAC_READBACK_EN.
module spi_dac_stream
    import spi_dac_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV,
    parameter int NUM_CH  = DEF_NUM_CH,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int CFG_W   = DEF_CFG_W,
    parameter int CS_GAP  = DEF_CS_GAP
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [CFG_W-1:0]         cfg_word,
    input  logic                     cfg_req,
    input  logic [ADDR_W-1:0]        start_addr,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [NUM_CH*DATA_W-1:0] s_data,
    output logic                     busy,
    output logic                     cfg_done,
    output logic                     frame_done,
    output logic                     cs_n,
    output logic                     sclk,
    output logic                     sdi,
    input  logic                     sdo,
    output logic [CFG_W-1:0]         rdbk_data,
    output logic                     rdbk_vld
);

    localparam int FRM_W = bits_per_frame(ADDR_W, NUM_CH, DATA_W);
    localparam int SH_W  = (FRM_W > CFG_W) ? FRM_W : CFG_W;
    localparam int MAX_B = (SH_W > CS_GAP) ? SH_W : CS_GAP;
    localparam int BW    = $clog2(MAX_B + 1);

    state_t          state;
    state_t          state_nxt;
    logic            cfg_pend;
    logic [SH_W-1:0] shreg;
    logic [SH_W-1:0] data_load;
    logic [SH_W-1:0] cfg_load;
    logic [BW-1:0]   nbits;
    logic            shifting;
    logic            tmr_start;
    logic            tmr_end;
    logic            tmr_last;
    logic            tmr_rise;
    logic            tmr_sclk;

    spi_dac_bit_timer #(
        .CLK_DIV (CLK_DIV),
        .BW      (BW)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .en        (busy),
        .nbits     (nbits),
        .bit_start (tmr_start),
        .bit_end   (tmr_end),
        .bit_last  (tmr_last),
        .sclk_rise (tmr_rise),
        .sclk      (tmr_sclk)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        busy       = 1'b1;
        s_ready    = 1'b0;
        cfg_done   = 1'b0;
        frame_done = 1'b0;
        shifting   = 1'b0;
        nbits      = BW'(CS_GAP);
        unique case (state)
            ST_IDLE: begin
                busy    = 1'b0;
                s_ready = !cfg_pend;
                if (cfg_pend)
                    state_nxt = ST_CFG;
                else if (s_valid)
                    state_nxt = ST_ADDR;
            end
            ST_CFG: begin
                shifting = 1'b1;
                nbits    = BW'(CFG_W);
                if (tmr_last) begin
                    state_nxt = ST_GAP;
                    cfg_done  = 1'b1;
                end
            end
            ST_ADDR: begin
                shifting = 1'b1;
                nbits    = BW'(ADDR_W);
                if (tmr_last) state_nxt = ST_DATA;
            end
            ST_DATA: begin
                shifting = 1'b1;
                nbits    = BW'(NUM_CH * DATA_W);
                if (tmr_last) begin
                    state_nxt  = ST_GAP;
                    frame_done = 1'b1;
                end
            end
            ST_GAP: begin
                if (tmr_last) state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Left-align both frame kinds so sdi is always the MSB;
    // channel 0 lands right below the address.
    always_comb begin
        data_load = '0;
        data_load[SH_W-1 -: ADDR_W] = start_addr;
        for (int i = 0; i < NUM_CH; i++)
            data_load[SH_W-1-ADDR_W-i*DATA_W -: DATA_W] =
                s_data[i*DATA_W +: DATA_W];
        cfg_load = '0;
        cfg_load[SH_W-1 -: CFG_W] = cfg_word;
    end

    // A new request wins over the clear so a cfg_req arriving on
    // the CFG entry cycle still schedules another frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cfg_pend <= 1'b1;
        else if (cfg_req)
            cfg_pend <= 1'b1;
        else if (state == ST_IDLE)
            cfg_pend <= 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg <= '0;
        end else if (state == ST_IDLE) begin
            if (cfg_pend)
                shreg <= cfg_load;
            else if (s_valid && s_ready)
                shreg <= data_load;
        end else if (shifting && tmr_end) begin
            shreg <= {shreg[SH_W-2:0], 1'b0};
        end
    end

    assign cs_n = !shifting;
    assign sclk = shifting && tmr_sclk;
    assign sdi  = shifting && shreg[SH_W-1];

    logic unused_start;
    assign unused_start = tmr_start;

`ifdef SPI_DAC_READBACK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rdbk_data <= '0;
        else if (state == ST_CFG && tmr_rise)
            rdbk_data <= {rdbk_data[CFG_W-2:0], sdo};
    end

    assign rdbk_vld = cfg_done;
`else
    assign rdbk_data = '0;
    assign rdbk_vld  = 1'b0;

    logic unused_rb;
    assign unused_rb = sdo ^ tmr_rise;
`endif

endmodule

// File: tb/tb_spi_dac_stream.sv
// Self-checking bench for spi_dac_stream with a frame-level reference model.
// Decodes SPI frames from the pins and compares them to expected frames.
module tb_spi_dac_stream;

    localparam int CLK_DIV = 6;
    localparam int NUM_CH  = 8;
    localparam int DATA_W  = 16;
    localparam int ADDR_W  = 8;
    localparam int CFG_W   = 24;
    localparam int CS_GAP  = 2;
    localparam int FBITS   = ADDR_W + NUM_CH * DATA_W;
    localparam int GAPCYC  = CS_GAP * CLK_DIV;

    logic clk = 0;
    logic rst = 1;
    logic [CFG_W-1:0] cfg_word = 24'h030A2C;
    logic cfg_req = 0;
    logic [ADDR_W-1:0] start_addr = '0;
    logic s_valid = 0;
    logic s_ready;
    logic [NUM_CH*DATA_W-1:0] s_data = '0;
    logic busy, cfg_done, frame_done, cs_n, sclk, sdi;
    logic sdo = 0;
    logic [CFG_W-1:0] rdbk_data;
    logic rdbk_vld;

    spi_dac_stream #(
        .CLK_DIV(CLK_DIV), .NUM_CH(NUM_CH), .DATA_W(DATA_W),
        .ADDR_W(ADDR_W), .CFG_W(CFG_W), .CS_GAP(CS_GAP)
    ) dut (
        .clk(clk), .rst(rst), .cfg_word(cfg_word), .cfg_req(cfg_req),
        .start_addr(start_addr), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .busy(busy), .cfg_done(cfg_done),
        .frame_done(frame_done), .cs_n(cs_n), .sclk(sclk), .sdi(sdi),
        .sdo(sdo), .rdbk_data(rdbk_data), .rdbk_vld(rdbk_vld)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           nb;
        logic [255:0] bits;
        int           low;
        int           gap;
    } frm_t;

    frm_t         frames[$];
    logic [255:0] exp_q[$];
    int           hs_cyc[$];

    int n_checks = 0;
    int n_pass   = 0;

    int cyc = 0;
    int cur_nb = 0, cur_low = 0, hi_run = 0, gap_at_fall = 0;
    logic [255:0] cur_bits = '0;
    bit in_frame = 0, prev_sclk = 0, prev_sready = 0;
    int cs_rise_cyc = 0, sready_rise_cyc = 0, sready_cnt = 0;
    int cfg_done_cnt = 0, frame_done_cnt = 0, rdbk_vld_cnt = 0;
    int idle_viol = 0;
    logic [CFG_W-1:0] rdbk_at_done = '0;
    logic [CFG_W-1:0] rb_word = 24'hA5C3F0;

    // Reference frame: address, then channels 0..N-1, all MSB first.
    function automatic logic [255:0] model_frame(
        input logic [ADDR_W-1:0] a,
        input logic [NUM_CH*DATA_W-1:0] d
    );
        logic [255:0] v, dd, m;
        v  = 256'(a);
        dd = 256'(d);
        m  = (256'(1) << DATA_W) - 256'(1);
        for (int c = 0; c < NUM_CH; c++) begin
            v  = (v << DATA_W) | (dd & m);
            dd = dd >> DATA_W;
        end
        return v;
    endfunction

    function automatic logic [NUM_CH*DATA_W-1:0] rnd_data();
        logic [NUM_CH*DATA_W-1:0] d;
        for (int i = 0; i < NUM_CH; i++)
            d[i*DATA_W +: DATA_W] = DATA_W'($urandom);
        return d;
    endfunction

    // Pin monitor: frames, pulses, handshakes, sdo stimulus.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            in_frame  = 0;
            cur_nb    = 0;
            cur_low   = 0;
            cur_bits  = '0;
            hi_run    = 0;
            prev_sclk = 0;
            prev_sready = 0;
            exp_q.delete();
        end else begin
            if (!cs_n) begin
                if (!in_frame) begin
                    in_frame    = 1;
                    gap_at_fall = hi_run;
                    cur_nb      = 0;
                    cur_low     = 0;
                    cur_bits    = '0;
                end
                cur_low++;
                if (sclk && !prev_sclk) begin
                    cur_bits = {cur_bits[254:0], sdi};
                    cur_nb++;
                end
            end else begin
                if (in_frame) begin
                    frames.push_back('{cur_nb, cur_bits, cur_low, gap_at_fall});
                    in_frame    = 0;
                    hi_run      = 0;
                    cur_nb      = 0;
                    cs_rise_cyc = cyc;
                end
                hi_run++;
                if (sclk || sdi) idle_viol++;
            end
            prev_sclk = sclk;
            if (s_valid && s_ready) begin
                hs_cyc.push_back(cyc);
                exp_q.push_back(model_frame(start_addr, s_data));
            end
            if (s_ready) sready_cnt++;
            if (s_ready && !prev_sready) sready_rise_cyc = cyc;
            prev_sready = s_ready;
            if (cfg_done) begin
                cfg_done_cnt++;
                rdbk_at_done = rdbk_data;
            end
            if (frame_done) frame_done_cnt++;
            if (rdbk_vld) rdbk_vld_cnt++;
            sdo = (cur_nb < CFG_W) ? rb_word[CFG_W-1-cur_nb] : 1'b0;
        end
    end

    task automatic wait_frames(input int n, input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (frames.size() >= n) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic handshake(output bit ok);
        int n0;
        n0 = hs_cyc.size();
        s_valid = 1;
        ok = 0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            if (hs_cyc.size() > n0) begin
                ok = 1;
                break;
            end
        end
        s_valid = 0;
    endtask

    task automatic test_reset();
        bit ok;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (cs_n !== 1'b1) $display("FAIL rst_cs_n got %b want 1", cs_n);
        else n_pass++;
        n_checks++;
        if (sclk !== 1'b0) $display("FAIL rst_sclk got %b want 0", sclk);
        else n_pass++;
        n_checks++;
        if (sdi !== 1'b0) $display("FAIL rst_sdi got %b want 0", sdi);
        else n_pass++;
        n_checks++;
        if (s_ready !== 1'b0) $display("FAIL rst_s_ready got %b want 0", s_ready);
        else n_pass++;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL rst_busy got %b want 0", busy);
        else n_pass++;
        n_checks++;
        if ({cfg_done, frame_done, rdbk_vld} !== 3'b000)
            $display("FAIL rst_pulses got %b want 000",
                     {cfg_done, frame_done, rdbk_vld});
        else n_pass++;
        n_checks++;
        if (rdbk_data !== '0) $display("FAIL rst_rdbk got %h want 0", rdbk_data);
        else n_pass++;

        frames.delete();
        rst = 0;
        wait_frames(1, 400, ok);
        n_checks++;
        if (!ok) $display("FAIL cfg_timeout got %0d frames want 1", frames.size());
        else n_pass++;
        if (ok) begin
            n_checks++;
            if (frames[0].nb !== CFG_W)
                $display("FAIL cfg_bits_n got %0d want %0d", frames[0].nb, CFG_W);
            else n_pass++;
            n_checks++;
            if (frames[0].bits !== 256'(24'h030A2C))
                $display("FAIL cfg_word got %h want 030a2c", frames[0].bits[23:0]);
            else n_pass++;
            n_checks++;
            if (frames[0].low !== CFG_W * CLK_DIV)
                $display("FAIL cfg_low got %0d want %0d", frames[0].low, CFG_W * CLK_DIV);
            else n_pass++;
        end
        for (int i = 0; i < 50 && sready_cnt == 0; i++) begin
            @(posedge clk); #1;
        end
        n_checks++;
        if (sready_cnt == 0) $display("FAIL sready_timeout got 0 want 1");
        else n_pass++;
        n_checks++;
        if (sready_rise_cyc - cs_rise_cyc !== GAPCYC)
            $display("FAIL sready_gap got %0d want %0d",
                     sready_rise_cyc - cs_rise_cyc, GAPCYC);
        else n_pass++;
        n_checks++;
        if (cfg_done_cnt !== 1 || frame_done_cnt !== 0)
            $display("FAIL cfg_done_cnt got %0d/%0d want 1/0",
                     cfg_done_cnt, frame_done_cnt);
        else n_pass++;
`ifdef SPI_DAC_READBACK_EN
        n_checks++;
        if (rdbk_at_done !== 24'hA5C3F0)
            $display("FAIL rdbk_data got %h want a5c3f0", rdbk_at_done);
        else n_pass++;
        n_checks++;
        if (rdbk_vld_cnt !== 1) $display("FAIL rdbk_vld got %0d want 1", rdbk_vld_cnt);
        else n_pass++;
`else
        n_checks++;
        if (rdbk_at_done !== '0) $display("FAIL rdbk_data got %h want 0", rdbk_at_done);
        else n_pass++;
        n_checks++;
        if (rdbk_vld_cnt !== 0) $display("FAIL rdbk_vld got %0d want 0", rdbk_vld_cnt);
        else n_pass++;
`endif
    endtask

    task automatic test_single_frame();
        bit ok;
        int fd0, cd0;
        logic [NUM_CH*DATA_W-1:0] d;
        frames.delete();
        fd0 = frame_done_cnt;
        cd0 = cfg_done_cnt;
        d = '0;
        d[15:0]  = 16'hFF00;
        d[31:16] = 16'hF00F;
        s_data = d;
        start_addr = 8'h14;
        handshake(ok);
        s_data = rnd_data();
        start_addr = ADDR_W'($urandom);
        n_checks++;
        if (!ok) $display("FAIL single_hs_timeout got 0 want 1");
        else n_pass++;
        wait_frames(1, 1300, ok);
        n_checks++;
        if (!ok) $display("FAIL single_timeout got %0d frames want 1", frames.size());
        else n_pass++;
        if (ok) begin
            n_checks++;
            if (frames[0].nb !== FBITS || frames[0].bits !== model_frame(8'h14, d))
                $display("FAIL single_bits got %0d:%h want %0d:%h", frames[0].nb,
                         frames[0].bits[FBITS-1:0], FBITS,
                         model_frame(8'h14, d));
            else n_pass++;
            n_checks++;
            if (frames[0].low !== FBITS * CLK_DIV)
                $display("FAIL single_low got %0d want %0d",
                         frames[0].low, FBITS * CLK_DIV);
            else n_pass++;
        end
        repeat (GAPCYC + 2) @(posedge clk);
        #1;
        n_checks++;
        if (frame_done_cnt - fd0 !== 1 || cfg_done_cnt !== cd0)
            $display("FAIL single_done got %0d/%0d want 1/0",
                     frame_done_cnt - fd0, cfg_done_cnt - cd0);
        else n_pass++;
    endtask

    task automatic test_random_frames();
        bit ok;
        logic [255:0] e;
        for (int k = 0; k < 3; k++) begin
            frames.delete();
            exp_q.delete();
            s_data = rnd_data();
            start_addr = ADDR_W'($urandom);
            handshake(ok);
            s_data = rnd_data();
            start_addr = ADDR_W'($urandom);
            wait_frames(1, 1300, ok);
            n_checks++;
            if (!ok || exp_q.size() != 1)
                $display("FAIL rand_timeout got %0d/%0d want 1/1",
                         frames.size(), exp_q.size());
            else begin
                e = exp_q.pop_front();
                if (frames[0].nb !== FBITS || frames[0].bits !== e)
                    $display("FAIL rand_bits got %h want %h",
                             frames[0].bits[FBITS-1:0], e[FBITS-1:0]);
                else n_pass++;
            end
            repeat (GAPCYC + 2) @(posedge clk);
            #1;
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int n, s0, s1;
        logic [255:0] e;
        frames.delete();
        exp_q.delete();
        hs_cyc.delete();
        s0 = sready_cnt;
        s_data = rnd_data();
        start_addr = ADDR_W'($urandom);
        s_valid = 1;
        n = 0;
        for (int i = 0; i < 6000 && n < 4; i++) begin
            @(posedge clk); #1;
            if (hs_cyc.size() > n) begin
                n = hs_cyc.size();
                s_data = rnd_data();
                start_addr = ADDR_W'($urandom);
            end
        end
        s_valid = 0;
        s1 = sready_cnt;
        n_checks++;
        if (n != 4) $display("FAIL b2b_hs_timeout got %0d want 4", n);
        else n_pass++;
        n_checks++;
        if (s1 - s0 !== 4) $display("FAIL b2b_sready got %0d want 4", s1 - s0);
        else n_pass++;
        wait_frames(4, 1300, ok);
        n_checks++;
        if (!ok) $display("FAIL b2b_timeout got %0d frames want 4", frames.size());
        else n_pass++;
        // Handshake period = frame + gap + one IDLE cycle.
        for (int i = 1; i < n; i++) begin
            n_checks++;
            if (hs_cyc[i] - hs_cyc[i-1] !== FBITS * CLK_DIV + GAPCYC + 1)
                $display("FAIL b2b_period got %0d want %0d",
                         hs_cyc[i] - hs_cyc[i-1], FBITS * CLK_DIV + GAPCYC + 1);
            else n_pass++;
        end
        for (int i = 0; i < frames.size() && exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            n_checks++;
            if (frames[i].bits !== e || frames[i].nb !== FBITS)
                $display("FAIL b2b_bits[%0d] got %h want %h", i,
                         frames[i].bits[FBITS-1:0], e[FBITS-1:0]);
            else n_pass++;
            if (i > 0) begin
                n_checks++;
                if (frames[i].gap !== GAPCYC + 1)
                    $display("FAIL b2b_gap[%0d] got %0d want %0d", i,
                             frames[i].gap, GAPCYC + 1);
                else n_pass++;
            end
        end
        repeat (GAPCYC + 2) @(posedge clk);
        #1;
    endtask

    task automatic test_cfg_mid_frame();
        bit ok;
        logic [255:0] e0, e1;
        logic [CFG_W-1:0] cw;
        frames.delete();
        exp_q.delete();
        hs_cyc.delete();
        cw = CFG_W'($urandom);
        cfg_word = cw;
        s_data = rnd_data();
        start_addr = ADDR_W'($urandom);
        handshake(ok);
        repeat (300) @(posedge clk);
        #1;
        cfg_req = 1;
        @(posedge clk); #1;
        cfg_req = 0;
        s_data = rnd_data();
        start_addr = ADDR_W'($urandom);
        s_valid = 1;
        for (int i = 0; i < 4000 && hs_cyc.size() < 2; i++) begin
            @(posedge clk); #1;
        end
        s_valid = 0;
        wait_frames(3, 1300, ok);
        n_checks++;
        if (!ok || exp_q.size() != 2)
            $display("FAIL cfgreq_timeout got %0d/%0d want 3/2",
                     frames.size(), exp_q.size());
        else begin
            n_pass++;
            e0 = exp_q.pop_front();
            e1 = exp_q.pop_front();
            n_checks++;
            if (frames[0].nb !== FBITS || frames[0].bits !== e0)
                $display("FAIL cfgreq_first got %0d:%h want %0d:%h",
                         frames[0].nb, frames[0].bits[FBITS-1:0],
                         FBITS, e0[FBITS-1:0]);
            else n_pass++;
            n_checks++;
            if (frames[1].nb !== CFG_W || frames[1].bits !== 256'(cw))
                $display("FAIL cfgreq_cfg got %0d:%h want %0d:%h",
                         frames[1].nb, frames[1].bits[CFG_W-1:0], CFG_W, cw);
            else n_pass++;
            n_checks++;
            if (frames[2].nb !== FBITS || frames[2].bits !== e1)
                $display("FAIL cfgreq_next got %0d:%h want %0d:%h",
                         frames[2].nb, frames[2].bits[FBITS-1:0],
                         FBITS, e1[FBITS-1:0]);
            else n_pass++;
        end
        repeat (GAPCYC + 2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_frame();
        bit ok;
        int n0;
        logic [255:0] e;
        cfg_word = 24'h5A17C3;
        s_data = rnd_data();
        start_addr = ADDR_W'($urandom);
        s_valid = 1;
        for (int i = 0; i < 100 && cs_n; i++) begin
            @(posedge clk); #1;
        end
        repeat (50) @(posedge clk);
        #3;
        rst = 1;
        #1;
        n_checks++;
        if ({cs_n, sclk, sdi} !== 3'b100)
            $display("FAIL midrst_pins got %b want 100", {cs_n, sclk, sdi});
        else n_pass++;
        n_checks++;
        if (busy !== 1'b0 || s_ready !== 1'b0)
            $display("FAIL midrst_status got %b%b want 00", busy, s_ready);
        else n_pass++;
        repeat (3) @(posedge clk);
        #1;
        frames.delete();
        n0 = hs_cyc.size();
        rst = 0;
        for (int i = 0; i < 600 && hs_cyc.size() == n0; i++) begin
            @(posedge clk); #1;
        end
        s_valid = 0;
        wait_frames(2, 1300, ok);
        n_checks++;
        if (!ok || exp_q.size() != 1)
            $display("FAIL midrst_timeout got %0d/%0d want 2/1",
                     frames.size(), exp_q.size());
        else begin
            n_pass++;
            e = exp_q.pop_front();
            n_checks++;
            if (frames[0].nb !== CFG_W || frames[0].bits !== 256'(24'h5A17C3))
                $display("FAIL midrst_cfg got %0d:%h want %0d:5a17c3",
                         frames[0].nb, frames[0].bits[CFG_W-1:0], CFG_W);
            else n_pass++;
            n_checks++;
            if (frames[1].nb !== FBITS || frames[1].bits !== e)
                $display("FAIL midrst_data got %h want %h",
                         frames[1].bits[FBITS-1:0], e[FBITS-1:0]);
            else n_pass++;
        end
        repeat (GAPCYC + 2) @(posedge clk);
        #1;
        n_checks++;
        if (idle_viol !== 0)
            $display("FAIL idle_levels got %0d want 0", idle_viol);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_random_frames();
        test_back_to_back();
        test_cfg_mid_frame();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
